calc_bcd_scan_display: RTL and testbench

//  Parametrised calculator front end: add/sub/mul on two W-bit unsigned operands,

---
 rtl/calc_bcd_scan_display.sv | 149 ++++++++++++++
 tb/tb_calc_bcd_scan_display.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/calc_bcd_scan_display.sv
// calc_bcd_scan_display: add/sub/mul, serial binary-to-BCD, 7-seg scan with sign/overflow.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module calc_bcd_scan_display #(
   parameter int W     = 4,
   parameter int NDIG  = 4,
   parameter int DIV_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   input  logic [1:0]      op,
   output logic            busy,
   output logic            valid,
   output logic            sign,
   output logic            ovf,
   output logic [6:0]      seg,
   output logic [NDIG-1:0] an
);
   localparam int RW = 2 * W;
   localparam int BW = 4 * (NDIG + 1);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int CW = $clog2(RW + 1);
   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;
   state_t           r_state, w_next;
   logic [W-1:0]     r_a, r_b;
   logic [1:0]       r_op;
   logic             r_fresh, r_neg, r_lost;
   logic [RW-1:0]    r_bin, w_res, w_ae, w_be;
   logic [BW-1:0]    r_bcd, w_adj;
   logic [CW-1:0]    r_cnt;
   logic [4*NDIG-1:0] r_disp;
   logic             r_valid, r_sign, r_ovf;
   logic [DIV_W-1:0] r_pre;
   logic [IW-1:0]    r_idx;
   logic [NDIG-1:0]  r_an;
   logic [6:0]       r_seg, w_seg, w_seg_dig;
   logic [3:0]       w_dig;
   logic             w_start, w_last, w_neg, w_blank;
   assign w_start = (r_state == S_IDLE) && (r_fresh || {a, b, op} != {r_a, r_b, r_op});
   assign w_last  = r_cnt == CW'(RW - 1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = (r_state == S_IDLE) ? (w_start ? S_CONV : S_IDLE) :
               (r_state == S_CONV) ? (w_last ? S_DONE : S_CONV) : S_IDLE;
   end
   always_comb begin
      busy = r_state == S_CONV;
   end
   assign w_ae  = {{W{1'b0}}, a};
   assign w_be  = {{W{1'b0}}, b};
   assign w_neg = (op == 2'b10) && (a < b);
   assign w_res = (op == 2'b01) ? w_ae + w_be :
                  (op == 2'b10) ? (w_neg ? w_be - w_ae : w_ae - w_be) :
                  (op == 2'b11) ? w_ae * w_be : '0;
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < NDIG + 1; i++)
         if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
   end
   // r_lost catches any digit pushed out of the work register so ovf stays exact for wide W
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_fresh <= 1'b1;
         r_neg   <= 1'b0;
         r_lost  <= 1'b0;
         r_bin   <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_disp  <= '0;
         r_valid <= 1'b0;
         r_sign  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_start) begin
         r_a     <= a;
         r_b     <= b;
         r_op    <= op;
         r_fresh <= 1'b0;
         r_neg   <= w_neg;
         r_lost  <= 1'b0;
         r_bin   <= w_res;
         r_bcd   <= '0;
         r_cnt   <= '0;
      end else if (r_state == S_CONV) begin
         {r_bcd, r_bin} <= {w_adj[BW-2:0], r_bin, 1'b0};
         r_lost         <= r_lost | w_adj[BW-1];
         r_cnt          <= r_cnt + CW'(1);
      end else if (r_state == S_DONE) begin
         r_disp  <= r_bcd[4*NDIG-1:0];
         r_ovf   <= r_lost | (r_bcd[BW-1 -: 4] != 4'd0);
         r_sign  <= r_neg;
         r_valid <= 1'b1;
      end
   end
   always_comb begin
      w_dig   = '0;
      w_blank = 1'b0;
      for (int i = 0; i < NDIG; i++)
         if (IW'(i) == r_idx) w_dig = r_disp[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      w_blank = r_idx != '0;
      for (int i = 0; i < NDIG; i++)
         if (IW'(i) >= r_idx && r_disp[4*i +: 4] != 4'd0) w_blank = 1'b0;
`endif
   end
   always_comb begin
      case (w_dig)
         4'd0:    w_seg_dig = 7'h40;
         4'd1:    w_seg_dig = 7'h79;
         4'd2:    w_seg_dig = 7'h24;
         4'd3:    w_seg_dig = 7'h30;
         4'd4:    w_seg_dig = 7'h19;
         4'd5:    w_seg_dig = 7'h12;
         4'd6:    w_seg_dig = 7'h02;
         4'd7:    w_seg_dig = 7'h78;
         4'd8:    w_seg_dig = 7'h00;
         4'd9:    w_seg_dig = 7'h10;
         default: w_seg_dig = 7'h7F;
      endcase
   end
   assign w_seg = r_ovf ? 7'h06 : !r_valid ? 7'h40 : w_blank ? 7'h7F : w_seg_dig;
   // an/seg show the current index on the tick, then the index advances
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre <= '0;
         r_idx <= '0;
         r_an  <= '1;
         r_seg <= 7'h7F;
      end else begin
         r_pre <= r_pre + DIV_W'(1);
         if (&r_pre) begin
            r_an  <= ~(NDIG'(1) << r_idx);
            r_seg <= w_seg;
            r_idx <= (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + IW'(1);
         end
      end
   end
   assign valid = r_valid;
   assign sign  = r_sign;
   assign ovf   = r_ovf;
   assign seg   = r_seg;
   assign an    = r_an;
endmodule

// File: tb/tb_calc_bcd_scan_display.sv
// tb_calc_bcd_scan_display: directed checks of arithmetic, BCD latency, scan order and overflow.
module tb_calc_bcd_scan_display;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] a = '0, b = '0;
   logic [1:0] op = '0;
   logic       busy0, valid0, sign0, ovf0, busy1, valid1, sign1, ovf1, busy2, valid2, sign2, ovf2;
   logic [6:0] seg0, seg1, seg2;
   logic [3:0] an0;
   logic [1:0] an1;
   logic [2:0] an2;
   logic [27:0] dg;
   int checks = 0;
   int errors = 0;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] Z = 7'h7F;
`else
   localparam logic [6:0] Z = 7'h40;
`endif

   calc_bcd_scan_display #(.W(4), .NDIG(4), .DIV_W(2)) u0 (.clk(clk), .rst(rst), .a(a), .b(b), .op(op),
      .busy(busy0), .valid(valid0), .sign(sign0), .ovf(ovf0), .seg(seg0), .an(an0));
   calc_bcd_scan_display #(.W(4), .NDIG(2), .DIV_W(2)) u1 (.clk(clk), .rst(rst), .a(a), .b(b), .op(op),
      .busy(busy1), .valid(valid1), .sign(sign1), .ovf(ovf1), .seg(seg1), .an(an1));
   calc_bcd_scan_display #(.W(4), .NDIG(3), .DIV_W(2)) u2 (.clk(clk), .rst(rst), .a(a), .b(b), .op(op),
      .busy(busy2), .valid(valid2), .sign(sign2), .ovf(ovf2), .seg(seg2), .an(an2));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic read_digits(output logic [27:0] d);
      logic [3:0] seen;
      seen = '0;
      d = '1;
      ticks(4);
      for (int n = 0; n < 40 && seen != 4'hF; n++) begin
         tick();
         for (int i = 0; i < 4; i++)
            if (an0 == ~(4'b0001 << i)) begin
               d[7*i +: 7] = seg0;
               seen[i] = 1'b1;
            end
      end
      chk("scan_complete", {28'd0, seen}, 32'hF);
   endtask

   task automatic check_digits(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                               input logic [6:0] d1, input logic [6:0] d0);
      read_digits(dg);
      chk({tag, "_d0"}, {25'd0, dg[6:0]},   {25'd0, d0});
      chk({tag, "_d1"}, {25'd0, dg[13:7]},  {25'd0, d1});
      chk({tag, "_d2"}, {25'd0, dg[20:14]}, {25'd0, d2});
      chk({tag, "_d3"}, {25'd0, dg[27:21]}, {25'd0, d3});
   endtask

   initial begin
      ticks(2);
      chk("rst_busy", busy0, 0);
      chk("rst_valid", valid0, 0);
      chk("rst_sign", sign0, 0);
      chk("rst_ovf", ovf0, 0);
      chk("rst_seg", seg0, 7'h7F);
      chk("rst_an", an0, 4'hF);
      a = 4'd9; b = 4'd7; op = 2'b01; rst = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 1) chk("busy_start", busy0, 1);
         if (c == 3) chk("an_before_tick", an0, 4'hF);
         if (c == 4) begin
            chk("an_step0", an0, 4'b1110);
            chk("seg_invalid0", seg0, 7'h40);
         end
         if (c == 8) begin
            chk("busy_last", busy0, 1);
            chk("valid_pre", valid0, 0);
            chk("an_step1", an0, 4'b1101);
            chk("seg_invalid1", seg0, 7'h40);
         end
         if (c == 9) begin
            chk("busy_end", busy0, 0);
            chk("valid_done_cycle", valid0, 0);
         end
         if (c == 10) begin
            chk("valid_set", valid0, 1);
            chk("sign_add", sign0, 0);
            chk("ovf_add", ovf0, 0);
            chk("ovf_add_n2", ovf1, 0);
         end
         if (c == 12) begin
            chk("an_step2", an0, 4'b1011);
            chk("seg_d2_16", seg0, Z);
            chk("an3_step2", an2, 3'b011);
         end
         if (c == 16) begin
            chk("an_step3", an0, 4'b0111);
            chk("seg_d3_16", seg0, Z);
            chk("an3_wrap", an2, 3'b110);
         end
         if (c == 20) begin
            chk("an_wrap", an0, 4'b1110);
            chk("seg_d0_16", seg0, 7'h02);
         end
      end
      check_digits("add16", Z, Z, 7'h79, 7'h02);

      a = 4'd3; b = 4'd9; op = 2'b10;
      ticks(12);
      chk("sub_sign", sign0, 1);
      chk("sub_valid", valid0, 1);
      check_digits("sub6", Z, Z, Z, 7'h02);
      op = 2'b01;
      ticks(12);
      chk("add12_sign", sign0, 0);
      check_digits("add12", Z, Z, 7'h79, 7'h24);

      a = 4'd15; b = 4'd15; op = 2'b11;
      ticks(12);
      chk("mul_ovf", ovf0, 0);
      chk("mul_sign", sign0, 0);
      chk("mul_ovf_n3", ovf2, 0);
      chk("mul_ovf_n2", ovf1, 1);
      check_digits("mul225", Z, 7'h24, 7'h24, 7'h12);
      chk("ovf_seg_a", seg1, 7'h06);
      ticks(4);
      chk("ovf_seg_b", seg1, 7'h06);

      a = 4'd9; b = 4'd7; op = 2'b01;
      tick();
      chk("chg_busy", busy0, 1);
      ticks(2);
      b = 4'd2;
      ticks(7);
      chk("chg_first_done", busy0, 0);
      tick();
      chk("chg_rerun", busy0, 1);
      ticks(12);
      chk("chg_valid", valid0, 1);
      check_digits("chg11", Z, Z, 7'h79, 7'h79);

      a = 4'd4; b = 4'd4; op = 2'b11;
      ticks(3);
      chk("mid_busy", busy0, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_valid", valid0, 0);
      chk("mid_rst_ovf", ovf0, 0);
      chk("mid_rst_sign", sign0, 0);
      chk("mid_rst_seg", seg0, 7'h7F);
      chk("mid_rst_an", an0, 4'hF);
      tick();
      rst = 1'b0;
      ticks(12);
      chk("restart_valid", valid0, 1);
      check_digits("restart16", Z, Z, 7'h79, 7'h02);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
